fetch_queue_pc: RTL and testbench

- Parametrised successor to the single-register program counter and +4 adder.
- Generates sequential fetch addresses, issues them to a synchronous 1-cycle-latency instruction memory, and buffers returned {pc, instr} pairs in a DEPTH-entry FIFO.
- Presents buffered pairs to decode over a valid/ready handshake.
- Supports decode back-pressure and a redirect (branch/exception) that flushes all younger fetches.

---
 rtl/fetch_queue_pc.sv | 112 +++++++++++
 tb/tb_fetch_queue_pc.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_pc.sv
// Sequential fetch PC generator with a DEPTH-entry {pc, instr} queue feeding decode.
// Optional performance counters are enabled by defining OLIVIA_FETCH_PERF_EN.
module fetch_queue_pc #(
  parameter int unsigned       ADDR_W       = 64,
  parameter int unsigned       INSTR_W      = 32,
  parameter int unsigned       DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       PC_STEP      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef OLIVIA_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetches,
  output logic [31:0]        perf_flushes,
  output logic [31:0]        perf_stalls
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   credit_used;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic               issue;
  logic               push;
  logic               pop;
  logic               not_empty;

  // An outstanding request reserves a slot, so a returning response always fits.
  always_comb begin
    credit_used = count + CNT_W'(inflight);
    not_empty   = (count != '0);
    issue       = rst && !redirect_valid && (credit_used < CNT_W'(DEPTH));
    push        = inflight && !redirect_valid;
    pop         = not_empty && !redirect_valid && out_ready;
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign out_valid = not_empty && !redirect_valid;
  assign out_pc    = not_empty ? pc_mem[rd_ptr] : '0;
  assign out_instr = not_empty ? instr_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      // Dropping inflight here kills the response arriving this cycle.
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(PC_STEP);
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef OLIVIA_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetches <= '0;
      perf_flushes <= '0;
      perf_stalls  <= '0;
    end else begin
      if (issue && (perf_fetches != '1))
        perf_fetches <= perf_fetches + 32'd1;
      if (redirect_valid && (perf_flushes != '1))
        perf_flushes <= perf_flushes + 32'd1;
      if (!issue && !redirect_valid && (perf_stalls != '1))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_pc.sv
// Self-checking bench for fetch_queue_pc: queue-based reference model plus directed scenarios.
module tb_fetch_queue_pc;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
`ifdef OLIVIA_FETCH_PERF_EN
  logic [31:0] perf_fetches, perf_flushes, perf_stalls;
`endif

  always #5 clk = ~clk;

  fetch_queue_pc #(
    .ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH), .RESET_VECTOR(64'h0), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
`ifdef OLIVIA_FETCH_PERF_EN
    , .perf_fetches(perf_fetches), .perf_flushes(perf_flushes), .perf_stalls(perf_stalls)
`endif
  );

  function automatic logic [31:0] imem_fn(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5A5A5;
  endfunction

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) imem_rdata <= imem_fn(imem_addr);

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, queued PCs, outstanding request.
  logic [63:0] m_fetch;
  logic [63:0] m_q[$];
  bit          m_infl;
  logic [63:0] m_infl_pc;

  // Values sampled during the most recent run_cycle.
  bit          s_req, s_valid, s_hs;
  logic [63:0] s_addr, s_pc;

  task automatic model_reset();
    m_fetch = 64'h0;
    m_q.delete();
    m_infl = 1'b0;
    m_infl_pc = '0;
  endtask

  task automatic run_cycle(input bit redir, input logic [63:0] rpc, input bit rdy);
    bit          e_req, e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    e_req   = !redir && ((m_q.size() + (m_infl ? 1 : 0)) < DEPTH);
    e_valid = !redir && (m_q.size() != 0);
    e_pc    = (m_q.size() != 0) ? m_q[0] : 64'h0;
    e_instr = (m_q.size() != 0) ? imem_fn(m_q[0]) : 32'h0;
    checks++;
    if (imem_req !== e_req) begin
      errors++; $display("FAIL imem_req @%0t: got %b expected %b", $time, imem_req, e_req);
    end
    if (e_req) begin
      checks++;
      if (imem_addr !== m_fetch) begin
        errors++; $display("FAIL imem_addr @%0t: got %h expected %h", $time, imem_addr, m_fetch);
      end
    end
    checks++;
    if (out_valid !== e_valid) begin
      errors++; $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, e_valid);
    end
    checks++;
    if (out_pc !== e_pc) begin
      errors++; $display("FAIL out_pc @%0t: got %h expected %h", $time, out_pc, e_pc);
    end
    checks++;
    if (out_instr !== e_instr) begin
      errors++; $display("FAIL out_instr @%0t: got %h expected %h", $time, out_instr, e_instr);
    end
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc;
    s_hs  = out_valid && rdy;
    @(posedge clk);
    if (redir) begin
      m_q.delete();
      m_fetch = rpc;
      m_infl  = 1'b0;
    end else begin
      if (e_valid && rdy) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      m_infl = e_req;
      if (e_req) begin
        m_infl_pc = m_fetch;
        m_fetch   = m_fetch + 64'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1; redirect_pc = '0;
    @(negedge clk);
    checks += 4;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    test_reset();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 64'h0, 1'b1);
      checks++;
      if (!(s_req && s_addr == 64'(4 * i))) begin
        errors++; $display("FAIL stream_issue[%0d]: got req=%b addr=%h expected addr=%h", i, s_req, s_addr, 4 * i);
      end
      checks++;
      if (i < 2) begin
        if (s_valid) begin errors++; $display("FAIL stream_latency[%0d]: got valid=1 expected 0", i); end
      end else if (!(s_valid && s_pc == 64'(4 * (i - 2)))) begin
        errors++; $display("FAIL stream_out[%0d]: got valid=%b pc=%h expected pc=%h", i, s_valid, s_pc, 4 * (i - 2));
      end
    end
  endtask

  task automatic test_backpressure();
    int          issues = 0;
    logic [63:0] last = '0;
    test_reset();
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b0, 64'h0, 1'b0);
      if (s_req) begin issues++; last = s_addr; end
    end
    checks++;
    if (issues != 4 || last != 64'hC) begin
      errors++; $display("FAIL bp_issues: got %0d last=%h expected 4 last=c", issues, last);
    end
    run_cycle(1'b0, 64'h0, 1'b1);
    checks++;
    if (!(s_hs && s_pc == 64'h0 && !s_req)) begin
      errors++; $display("FAIL bp_pop: got hs=%b pc=%h req=%b expected hs=1 pc=0 req=0", s_hs, s_pc, s_req);
    end
    run_cycle(1'b0, 64'h0, 1'b0);
    checks++;
    if (!(s_req && s_addr == 64'h10)) begin
      errors++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=10", s_req, s_addr);
    end
  endtask

  task automatic test_redirect();
    test_reset();
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 64'h0, 1'b0);
    run_cycle(1'b1, 64'h1000, 1'b1);
    checks++;
    if (s_valid || s_hs || s_req) begin
      errors++; $display("FAIL redir_cycle: got valid=%b req=%b expected 0 0", s_valid, s_req);
    end
    run_cycle(1'b0, 64'h0, 1'b1);
    checks++;
    if (!(s_req && s_addr == 64'h1000 && !s_valid)) begin
      errors++; $display("FAIL redir_issue: got req=%b addr=%h valid=%b expected 1 1000 0", s_req, s_addr, s_valid);
    end
    run_cycle(1'b0, 64'h0, 1'b1);
    checks++;
    if (s_valid) begin errors++; $display("FAIL redir_latency: got valid=1 expected 0"); end
    run_cycle(1'b0, 64'h0, 1'b1);
    checks++;
    if (!(s_valid && s_pc == 64'h1000)) begin
      errors++; $display("FAIL redir_first: got valid=%b pc=%h expected 1 1000", s_valid, s_pc);
    end
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b0, 64'h0, 1'(i % 2));
      checks++;
      if (s_valid && (s_pc < 64'h1000 || s_pc > 64'h1100)) begin
        errors++; $display("FAIL redir_stale: got pc=%h expected >=1000", s_pc);
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_a [4];
    exp_a[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp_a[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_a[2] = 64'h0;                   exp_a[3] = 64'h4;
    run_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 64'h0, 1'b1);
      checks++;
      if (!(s_req && s_addr == exp_a[i])) begin
        errors++; $display("FAIL wrap[%0d]: got req=%b addr=%h expected %h", i, s_req, s_addr, exp_a[i]);
      end
    end
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 64'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_cycle(1'b1, 64'h3000, 1'b1);
    run_cycle(1'b1, 64'h4000, 1'b0);
    run_cycle(1'b1, 64'h5000, 1'b1);
    run_cycle(1'b0, 64'h0, 1'b1);
    checks++;
    if (!(s_req && s_addr == 64'h5000)) begin
      errors++; $display("FAIL b2b_redirect: got req=%b addr=%h expected 5000", s_req, s_addr);
    end
  endtask

  task automatic test_random(input int cycles, input int ready_pct, input int redir_pct);
    logic [63:0] rpc;
    bit          redir;
    for (int i = 0; i < cycles; i++) begin
      redir = ($urandom_range(99) < 32'(redir_pct));
      rpc   = {$urandom(), $urandom()} & ~64'h3;
      if ($urandom_range(3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0;
      run_cycle(redir, rpc, $urandom_range(99) < 32'(ready_pct));
    end
  endtask

  task automatic test_midop_reset();
    test_random(20, 50, 0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0) begin
      errors++; $display("FAIL midop_reset: got req=%b valid=%b pc=%h instr=%h expected all 0",
                         imem_req, out_valid, out_pc, out_instr);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    test_random(20, 70, 0);
  endtask

`ifdef OLIVIA_FETCH_PERF_EN
  task automatic test_perf();
    test_reset();
    checks++;
    if (perf_fetches !== 32'd0 || perf_flushes !== 32'd0 || perf_stalls !== 32'd0) begin
      errors++; $display("FAIL perf_reset: got %0d %0d %0d expected 0 0 0", perf_fetches, perf_flushes, perf_stalls);
    end
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 64'h0, 1'b1);
    run_cycle(1'b1, 64'h2000, 1'b1);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 64'h0, 1'b0);
    checks += 3;
    if (perf_fetches !== 32'd14) begin errors++; $display("FAIL perf_fetches: got %0d expected 14", perf_fetches); end
    if (perf_flushes !== 32'd1) begin errors++; $display("FAIL perf_flushes: got %0d expected 1", perf_flushes); end
    if (perf_stalls !== 32'd1) begin errors++; $display("FAIL perf_stalls: got %0d expected 1", perf_stalls); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_random(300, 80, 3);
    test_random(300, 30, 5);
    test_random(200, 60, 30);
    test_midop_reset();
`ifdef OLIVIA_FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
